// File: rtl/mem_line_server.sv
// Fixed-latency line memory answering I-cache line reads and D-cache line reads/write-backs.
// One transaction in flight; write-backs win, competing reads alternate.
module mem_line_server #(
  parameter int ARCH_BITS        = 32,
  parameter int MEMORY_LINE_BITS = 128,
  parameter int INDEX_BITS       = 10,
  parameter int LATENCY          = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ARCH_BITS-1:0]        iReadAddr,
  input  logic                        iReadReq,
  output logic [MEMORY_LINE_BITS-1:0] iReadLine,
  output logic                        iReadLineValid,
  input  logic [ARCH_BITS-1:0]        dReadAddr,
  input  logic                        dReadReq,
  output logic [MEMORY_LINE_BITS-1:0] dReadLine,
  output logic                        dReadLineValid,
  input  logic [ARCH_BITS-1:0]        dWriteAddr,
  input  logic [MEMORY_LINE_BITS-1:0] dWriteLine,
  input  logic                        dWriteReq,
  output logic                        dWriteAck
);
  localparam int OFF   = $clog2(MEMORY_LINE_BITS / 8);
  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {K_IR, K_DR, K_DW} kind_t;

  state_t                      state_q;
  kind_t                       kind_q, kind_d;
  logic [7:0]                  cnt_q;
  logic [INDEX_BITS-1:0]       idx_q, idx_d;
  logic [MEMORY_LINE_BITS-1:0] wdata_q;
  logic                        rr_last_d_q;
  logic                        any_req_d;
  logic [MEMORY_LINE_BITS-1:0] mem [DEPTH];

  // Offset and upper address bits are deliberately dropped (line aligned, aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iReadAddr[ARCH_BITS-1:OFF+INDEX_BITS], iReadAddr[OFF-1:0],
                              dReadAddr[ARCH_BITS-1:OFF+INDEX_BITS], dReadAddr[OFF-1:0],
                              dWriteAddr[ARCH_BITS-1:OFF+INDEX_BITS], dWriteAddr[OFF-1:0]};

  always_comb begin
    any_req_d = iReadReq | dReadReq | dWriteReq;
    kind_d    = K_IR;
    idx_d     = iReadAddr[OFF+INDEX_BITS-1:OFF];
    if (dWriteReq) begin
      kind_d = K_DW;
      idx_d  = dWriteAddr[OFF+INDEX_BITS-1:OFF];
    end else if (dReadReq && (!iReadReq || !rr_last_d_q)) begin
      kind_d = K_DR;
      idx_d  = dReadAddr[OFF+INDEX_BITS-1:OFF];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      kind_q         <= K_IR;
      cnt_q          <= '0;
      idx_q          <= '0;
      wdata_q        <= '0;
      rr_last_d_q    <= 1'b1;
      iReadLine      <= '0;
      dReadLine      <= '0;
      iReadLineValid <= 1'b0;
      dReadLineValid <= 1'b0;
      dWriteAck      <= 1'b0;
    end else begin
      iReadLineValid <= 1'b0;
      dReadLineValid <= 1'b0;
      dWriteAck      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            kind_q  <= kind_d;
            idx_q   <= idx_d;
            wdata_q <= dWriteLine;
            cnt_q   <= CNT_INIT;
            if (kind_d != K_DW) rr_last_d_q <= (kind_d == K_DR);
            state_q <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          case (kind_q)
            K_IR: begin
              iReadLine      <= mem[idx_q];
              iReadLineValid <= 1'b1;
            end
            K_DR: begin
              dReadLine      <= mem[idx_q];
              dReadLineValid <= 1'b1;
            end
            default: dWriteAck <= 1'b1;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; a reset in the commit cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP && kind_q == K_DW) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_line_server.sv
// Bench for mem_line_server: directed vector table, arbitration/reset sequences, and
// randomized multi-port traffic against a line-array reference model.
module tb_mem_line_server;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  iReadAddr, dReadAddr, dWriteAddr;
  logic         iReadReq, dReadReq, dWriteReq;
  logic [127:0] iReadLine, dReadLine, dWriteLine;
  logic         iReadLineValid, dReadLineValid, dWriteAck;

  always #5 clk = ~clk;

  mem_line_server #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .iReadAddr(iReadAddr), .iReadReq(iReadReq), .iReadLine(iReadLine), .iReadLineValid(iReadLineValid),
    .dReadAddr(dReadAddr), .dReadReq(dReadReq), .dReadLine(dReadLine), .dReadLineValid(dReadLineValid),
    .dWriteAddr(dWriteAddr), .dWriteLine(dWriteLine), .dWriteReq(dWriteReq), .dWriteAck(dWriteAck)
  );

  typedef enum int {IR = 0, DR = 1, DW = 2, NONE = 3} kind_e;
  typedef struct {
    kind_e        k;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: line array by index, last returned lines, last read port served.
  logic [127:0] mdl_mem [int];
  int           wr_idx_q [$];
  logic [127:0] mdl_iline, mdl_dline;
  kind_e        mdl_last_read;

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd1024);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_iline     = '0;
    mdl_dline     = '0;
    mdl_last_read = DR;
  endtask

  task automatic raise(input kind_e k, input logic [31:0] a, input logic [127:0] d);
    case (k)
      IR: begin iReadAddr = a; iReadReq = 1'b1; end
      DR: begin dReadAddr = a; dReadReq = 1'b1; end
      DW: begin dWriteAddr = a; dWriteLine = d; dWriteReq = 1'b1; end
      default: ;
    endcase
  endtask

  // Called at a negedge with the DUT idle; waits for the next response and checks it.
  task automatic serve(input string name, output kind_e got);
    kind_e        exp_k;
    logic [127:0] exp_line;
    int           idx, cyc;
    if (dWriteReq)                 exp_k = DW;
    else if (iReadReq && dReadReq) exp_k = (mdl_last_read == DR) ? IR : DR;
    else if (iReadReq)             exp_k = IR;
    else                           exp_k = DR;
    idx = (exp_k == DW) ? line_idx(dWriteAddr) : (exp_k == IR) ? line_idx(iReadAddr) : line_idx(dReadAddr);
    exp_line = (exp_k != DW && mdl_mem.exists(idx)) ? mdl_mem[idx] : '0;
    got = NONE;
    cyc = 0;
    while (got == NONE && cyc < L + 4) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (int'(iReadLineValid) + int'(dReadLineValid) + int'(dWriteAck) > 1)
        chk({name, " single_pulse"}, {iReadLineValid, dReadLineValid, dWriteAck}, 0);
      if (dWriteAck) got = DW;
      else if (dReadLineValid) got = DR;
      else if (iReadLineValid) got = IR;
    end
    chk({name, " kind"}, got, exp_k);
    chk({name, " latency"}, cyc, L + 1);
    if (exp_k == DW) begin
      if (!mdl_mem.exists(idx)) wr_idx_q.push_back(idx);
      mdl_mem[idx] = dWriteLine;
    end else begin
      if (exp_k == IR) mdl_iline = exp_line; else mdl_dline = exp_line;
      mdl_last_read = exp_k;
    end
    chk({name, " iline"}, iReadLine, mdl_iline);
    chk({name, " dline"}, dReadLine, mdl_dline);
    case (got)
      IR: iReadReq = 1'b0;
      DR: dReadReq = 1'b0;
      DW: dWriteReq = 1'b0;
      default: begin iReadReq = 1'b0; dReadReq = 1'b0; dWriteReq = 1'b0; end
    endcase
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  vec_t  vecs [10];
  kind_e got;

  initial begin
    vecs[0] = '{DW, 32'h0000_0030, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, '0};
    vecs[1] = '{IR, 32'h0000_0030, '0, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5};
    vecs[2] = '{DW, 32'h0000_0040, 128'h1234, '0};
    vecs[3] = '{DR, 32'h0000_004C, '0, 128'h1234};
    vecs[4] = '{IR, 32'h0000_4030, '0, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5};
    vecs[5] = '{DR, 32'h0000_003F, '0, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5};
    vecs[6] = '{DW, 32'hFFFF_FFF0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, '0};
    vecs[7] = '{IR, 32'h0000_3FF8, '0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
    vecs[8] = '{DW, 32'h0000_0050, 128'h0BAD_F00D, '0};
    vecs[9] = '{DR, 32'h8000_0054, '0, 128'h0BAD_F00D};

    rst = 1'b1;
    iReadReq = 1'b0; dReadReq = 1'b0; dWriteReq = 1'b0;
    iReadAddr = '0; dReadAddr = '0; dWriteAddr = '0; dWriteLine = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("reset iline", iReadLine, 0);
    chk("reset dline", dReadLine, 0);
    chk("reset pulses", {iReadLineValid, dReadLineValid, dWriteAck}, 0);

    foreach (vecs[i]) begin
      raise(vecs[i].k, vecs[i].addr, vecs[i].data);
      serve($sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d kind_tbl", i), got, vecs[i].k);
      if (vecs[i].k == IR) chk($sformatf("vec%0d data", i), iReadLine, vecs[i].exp);
      if (vecs[i].k == DR) chk($sformatf("vec%0d data", i), dReadLine, vecs[i].exp);
    end

    // Reset two cycles into BUSY of a write to line 5: aborted, line keeps old data.
    raise(DW, 32'h0000_0050, 128'hFFFF_EEEE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dWriteReq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort outputs", {iReadLine, dReadLine}, 0);
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      chk("abort no_pulse", {iReadLineValid, dReadLineValid, dWriteAck}, 0);
    end
    raise(DR, 32'h0000_0058, '0);
    serve("abort readback", got);
    chk("abort readback data", dReadLine, 128'h0BAD_F00D);

    // Both reads together after a D read: I first, then D, back to back.
    raise(IR, 32'h0000_0030, '0);
    raise(DR, 32'h0000_0040, '0);
    serve("rr first", got);
    chk("rr first is I", got, IR);
    serve("rr second", got);
    chk("rr second is D", got, DR);
    chk("rr second data", dReadLine, 128'h1234);

    // All three: write wins, then reads alternate (last read was D).
    raise(DW, 32'h0000_0030, 128'h7777);
    raise(IR, 32'h0000_0040, '0);
    raise(DR, 32'h0000_0030, '0);
    serve("all3 first", got);
    chk("all3 first is W", got, DW);
    serve("all3 second", got);
    chk("all3 second is I", got, IR);
    serve("all3 third", got);
    chk("all3 third is D", got, DR);
    chk("all3 raw data", dReadLine, 128'h7777);

    // Randomized traffic: each round any idle port may raise a request.
    for (int r = 0; r < 60; r++) begin
      if (!dWriteReq && ($urandom_range(0, 2) == 0 || wr_idx_q.size() == 0))
        raise(DW, {$urandom_range(0, 262143), 10'($urandom_range(0, 15)), 4'($urandom)}, rnd128());
      if (wr_idx_q.size() > 0) begin
        if (!iReadReq && $urandom_range(0, 1) == 1)
          raise(IR, {18'($urandom), 10'(wr_idx_q[$urandom_range(0, wr_idx_q.size() - 1)]), 4'($urandom)}, '0);
        if (!dReadReq && $urandom_range(0, 1) == 1)
          raise(DR, {18'($urandom), 10'(wr_idx_q[$urandom_range(0, wr_idx_q.size() - 1)]), 4'($urandom)}, '0);
      end
      if (!iReadReq && !dReadReq && !dWriteReq)
        raise(DR, {22'd0, 10'(wr_idx_q[0]), 4'd0}, '0);
      serve($sformatf("rnd%0d", r), got);
    end
    while (iReadReq || dReadReq || dWriteReq) serve("drain", got);

    @(negedge clk);
    chk("final idle pulses", {iReadLineValid, dReadLineValid, dWriteAck}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
